symbol_encoder: RTL

- Upstream front-end for the symbol-sequence FSM that consumes the 2-bit symbol code (X1,X0) and drives the LED.
- Takes three raw push-buttons (A, B, C), synchronises and debounces them, and resolves simultaneous presses by priority.
- Emits exactly one symbol code per physical press: A=01, B=10, C=11, idle=00.
- Holds the code for a fixed number of clock cycles so the downstream FSM samples it once.

---
 rtl/symbol_encoder.sv | 132 +++++++++++++
 1 files changed

// File: rtl/symbol_encoder.sv
// symbol_encoder: push-button front end for the symbol-sequence FSM.
// Synchronises and debounces three raw buttons, resolves simultaneous presses
// by priority (C > B > A) and emits exactly one 2-bit symbol code per press.
// The code is held on X1/X0 for HOLD_CYCLES clocks and then returns to 00.
module symbol_encoder #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_a,
  input  logic btn_b,
  input  logic btn_c,
  output logic X1,
  output logic X0,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    EMIT     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  // Terminal counts: debounce/release accept on the Nth matching sample;
  // hold counter starts at 1 on entry to EMIT.
  localparam logic [7:0] DB_LAST   = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES);

  logic [2:0] sync_p0;
  logic [2:0] sync_p1;
  logic [1:0] sym;
  state_t     state;
  logic [7:0] cnt;
  logic [7:0] hcnt;
  logic [1:0] cap;
  logic [1:0] code;

  // Priority encoder: bit 2 = C, bit 1 = B, bit 0 = A.
  function automatic logic [1:0] prio_enc(input logic [2:0] b);
    logic [1:0] r;
    if (b[2])      r = 2'b11;
    else if (b[1]) r = 2'b10;
    else if (b[0]) r = 2'b01;
    else           r = 2'b00;
    return r;
  endfunction

  // Stage p0/p1: two-flop synchroniser for the asynchronous buttons.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_p0 <= 3'b000;
      sync_p1 <= 3'b000;
    end else begin
      sync_p0 <= {btn_c, btn_b, btn_a};
      sync_p1 <= sync_p0;
    end
  end

  assign sym = prio_enc(sync_p1);

  // Debounce / emit / release FSM with registered code and busy outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 8'd0;
      hcnt  <= 8'd0;
      cap   <= 2'b00;
      code  <= 2'b00;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sym != 2'b00) begin
            cap   <= sym;
            cnt   <= 8'd1;
            state <= DEBOUNCE;
            busy  <= 1'b1;
          end
        end
        DEBOUNCE: begin
          if (sym == 2'b00) begin
            // Short press or bounce: abandon without emitting.
            state <= IDLE;
            busy  <= 1'b0;
          end else if (sym != cap) begin
            // A different (e.g. higher-priority) code restarts debounce.
            cap <= sym;
            cnt <= 8'd1;
          end else if (cnt == DB_LAST) begin
            code  <= cap;
            hcnt  <= 8'd1;
            state <= EMIT;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        EMIT: begin
          // Inputs are ignored here so the code never changes mid-hold.
          if (hcnt == HOLD_LAST) begin
            code  <= 2'b00;
            cnt   <= 8'd0;
            state <= RELEASE;
          end else begin
            hcnt <= hcnt + 8'd1;
          end
        end
        RELEASE: begin
          // Wait for a debounced release so a held button emits only once.
          if (sym != 2'b00) begin
            cnt <= 8'd0;
          end else if (cnt == DB_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          code  <= 2'b00;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign X1 = code[1];
  assign X0 = code[0];

endmodule
